// File: rtl/prior_arbiter8_if.sv
// prior_arbiter8_if: request/grant bundle between the requesters and prior_arbiter8.
// master = requester side (drives req), slave = arbiter side (drives grant outputs).
interface prior_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       expired;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  expired
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output busy,
        output expired
    );
endinterface

// File: rtl/prior_arbiter8.sv
// prior_arbiter8: 8-requester arbiter with grant hold, forced release after
// MAX_HOLD cycles (0 = unlimited) and a one-cycle turnaround between tenures.
// Optional macro PRIOR_ARB_ROUND_ROBIN_EN: rotating priority starting just
// below the last released index; otherwise fixed priority, highest index wins.
module prior_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input logic              clk,
    input logic              rst_n,
    prior_arbiter8_if.slave  bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam bit         HOLD_EN    = (MAX_HOLD != 0);

    logic [1:0] state;
    logic [7:0] hold_cnt;
    logic [7:0] mask;
    logic [7:0] gnt_q;
    logic [2:0] id_q;
    logic       busy_q;
    logic       expired_q;

    logic [7:0] elig;
    logic       any_elig;
    logic [2:0] win;
    logic       drop;
    logic       expire_now;
    logic [7:0] set_mask;

`ifdef PRIOR_ARB_ROUND_ROBIN_EN
    logic [2:0] last_id;

    // Rotating search: last-1, last-2, ... wrapping down to last itself.
    // Later loop iterations overwrite earlier ones, so k=1 has top priority.
    function automatic logic [2:0] pick_rotate(input logic [7:0] e, input logic [2:0] last);
        logic [2:0] w;
        logic [2:0] idx;
        w = last;
        for (int k = 8; k >= 1; k--) begin
            idx = last - 3'(k);
            if (e[idx]) w = idx;
        end
        return w;
    endfunction
`else
    // Fixed priority: the highest set index overwrites lower ones.
    function automatic logic [2:0] pick_fixed(input logic [7:0] e);
        logic [2:0] w;
        w = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) w = 3'(i);
        end
        return w;
    endfunction
`endif

    // Winner selection and release/expiry decisions for the current cycle.
    always_comb begin
        elig     = bus.req & ~mask;
        any_elig = |elig;
`ifdef PRIOR_ARB_ROUND_ROBIN_EN
        win      = pick_rotate(elig, last_id);
`else
        win      = pick_fixed(elig);
`endif
        drop       = (state == ST_GRANT) && !bus.req[id_q];
        // A dropping request releases normally even if the limit is reached.
        expire_now = (state == ST_GRANT) && !drop && HOLD_EN && (hold_cnt == HOLD_LIMIT);
        set_mask   = expire_now ? (8'b1 << id_q) : 8'h00;
    end

    // Main arbitration state machine and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hold_cnt  <= 8'd0;
            gnt_q     <= 8'h00;
            id_q      <= 3'd0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_elig) begin
                        state    <= ST_GRANT;
                        gnt_q    <= 8'b1 << win;
                        id_q     <= win;
                        busy_q   <= 1'b1;
                        hold_cnt <= 8'd1;
                    end
                end
                ST_GRANT: begin
                    if (drop) begin
                        state  <= ST_RELEASE;
                        gnt_q  <= 8'h00;
                        busy_q <= 1'b0;
                    end else if (expire_now) begin
                        state     <= ST_RELEASE;
                        gnt_q     <= 8'h00;
                        busy_q    <= 1'b0;
                        expired_q <= 1'b1;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Block mask: cleared by a sampled-low request, set on forced release (set wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= 8'h00;
        end else begin
            mask <= (mask & bus.req) | set_mask;
        end
    end

`ifdef PRIOR_ARB_ROUND_ROBIN_EN
    // Remember the index released at the end of each tenure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id <= 3'd0;
        end else if (drop || expire_now) begin
            last_id <= id_q;
        end
    end
`endif

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = id_q;
    assign bus.busy    = busy_q;
    assign bus.expired = expired_q;

endmodule

// File: tb/tb_prior_arbiter8.sv
// tb_prior_arbiter8: directed scenarios plus randomized requests, checked
// every cycle against a tenure-level reference model.
module tb_prior_arbiter8;

    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst_n;

    prior_arbiter8_if bus();

    prior_arbiter8 #(.MAX_HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who owns the resource, for how long, turnaround left,
    // blocked requesters, last released index, last granted index.
    int       m_owner = -1;
    int       m_ticks = 0;
    int       m_cool  = 0;
    int       m_last  = 0;
    int       m_id    = 0;
    bit       m_exp   = 1'b0;
    bit [7:0] m_mask  = 8'h00;

    int grant_log[$];
    bit prev_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    function automatic int pick(input bit [7:0] e);
`ifdef PRIOR_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++) begin
            int idx;
            idx = (m_last - k + 8) % 8;
            if (e[idx]) return idx;
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (e[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ticks = 0; m_cool = 0; m_last = 0;
        m_id = 0; m_exp = 1'b0; m_mask = 8'h00;
    endtask

    task automatic model_step(input bit [7:0] r);
        bit [7:0] elig;
        bit [7:0] nmask;
        int w;
        elig  = r & ~m_mask;
        nmask = m_mask & r;
        m_exp = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_last = m_owner; m_owner = -1; m_cool = 1;
            end else if (HOLD != 0 && m_ticks == HOLD) begin
                m_exp = 1'b1; nmask[m_owner] = 1'b1;
                m_last = m_owner; m_owner = -1; m_cool = 1;
            end else if (m_ticks < 255) begin
                m_ticks++;
            end
        end else if (m_cool > 0) begin
            m_cool = 0;
        end else begin
            w = pick(elig);
            if (w >= 0) begin
                m_owner = w; m_id = w; m_ticks = 1;
            end
        end
        m_mask = nmask;
    endtask

    task automatic compare_outputs();
        check_eq("gnt", bus.gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check_eq("busy", bus.busy, (m_owner >= 0) ? 32'd1 : 32'd0);
        check_eq("gnt_id", bus.gnt_id, m_id);
        check_eq("expired", bus.expired, m_exp);
        if (bus.busy && !prev_busy) grant_log.push_back(int'(bus.gnt_id));
        prev_busy = bus.busy;
    endtask

    task automatic cycle_rst(input logic [7:0] r, input logic rv);
        @(negedge clk);
        compare_outputs();
        bus.req = r;
        rst_n   = rv;
        @(posedge clk);
        if (!rv) model_reset();
        else model_step(r);
    endtask

    task automatic cycle(input logic [7:0] r);
        cycle_rst(r, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt;
        int exp_cnt;
        int rr_exp[9];
        int guard;
        logic [7:0] r;

        rst_n   = 1'b0;
        bus.req = 8'hFF;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset held with all requests, then release.
        repeat (3) cycle_rst(8'hFF, 1'b0);
        cycle(8'hFF);
        #1;
        check_eq("rst_first_gnt", bus.gnt, 8'h80);
        check_eq("rst_first_id", bus.gnt_id, 3'd7);
        repeat (12) cycle(8'hFF);
        repeat (3) cycle(8'h00);

        // Fixed priority pair and turnaround gap.
        cycle(8'h24);
        #1 check_eq("prio_gnt", bus.gnt, 8'h20);
        cycle(8'h24);
        cycle(8'h04);
        #1 check_eq("gap1", bus.gnt, 8'h00);
        cycle(8'h04);
        #1 check_eq("gap2", bus.gnt, 8'h00);
        cycle(8'h04);
        #1 check_eq("prio_next", bus.gnt, 8'h04);
        repeat (3) cycle(8'h00);

        // Hold limit: a single held request is force-released after HOLD cycles.
        hi_cnt = 0; exp_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(8'h01);
            #1;
            if (bus.gnt != 8'h00) hi_cnt++;
            if (bus.expired) exp_cnt++;
        end
        check_eq("hold_cycles", hi_cnt, HOLD);
        check_eq("hold_expired", exp_cnt, 1);
        cycle(8'h00);
        cycle(8'h01);
        #1 check_eq("hold_regrant", bus.gnt, 8'h01);
        repeat (3) cycle(8'h00);

        // Request drop on the cycle the limit is reached: normal release.
        repeat (HOLD) cycle(8'h01);
        cycle(8'h00);
        #1;
        check_eq("simul_expired", bus.expired, 1'b0);
        check_eq("simul_gnt", bus.gnt, 8'h00);
        cycle(8'h01);
        cycle(8'h01);
        #1 check_eq("simul_regrant", bus.gnt, 8'h01);
        repeat (3) cycle(8'h00);

        // Asynchronous reset in the middle of a tenure.
        cycle(8'h10);
        cycle(8'h10);
        @(negedge clk);
        compare_outputs();
        check_eq("async_pre_gnt", bus.gnt, 8'h10);
        rst_n = 1'b0;
        #1;
        check_eq("async_gnt", bus.gnt, 8'h00);
        check_eq("async_busy", bus.busy, 1'b0);
        check_eq("async_expired", bus.expired, 1'b0);
        model_reset();
        prev_busy = 1'b0;
        @(posedge clk);
        cycle_rst(8'h00, 1'b0);

        // Rotation sequence: every winner drops after one grant cycle.
        grant_log.delete();
        guard = 0;
        while (grant_log.size() < 9 && guard < 200) begin
            r = 8'hFF;
            if (m_owner >= 0) r[m_owner] = 1'b0;
            cycle(r);
            guard++;
        end
`ifdef PRIOR_ARB_ROUND_ROBIN_EN
        rr_exp = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
`else
        rr_exp = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`endif
        check_eq("rr_count", grant_log.size(), 9);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("rr_order%0d", i),
                     (i < grant_log.size()) ? grant_log[i] : -1, rr_exp[i]);
        end
        repeat (3) cycle(8'h00);

        // Randomized requests, mostly stable so tenures and expiries occur.
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       r = 8'($urandom);
                1:       r = r ^ (8'b1 << $urandom_range(0, 7));
                2:       r = 8'h00;
                default: r = r;
            endcase
            cycle(r);
        end
        cycle(8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
